// File: rtl/pw_mul_ctrl.sv
// Pointwise multiply sequencer: streams coefficient pairs from the operand RAMs,
// multiplies, Barrett-reduces mod 8380417 and writes results back in order.

module red_D (
    input  logic [45:0] x_i,
    output logic [22:0] r_o
);
    // m = floor(2^46 / q); the quotient estimate is short by at most 2,
    // so two conditional subtractions finish the reduction.
    localparam logic [69:0] M   = 70'd8396807;
    localparam logic [45:0] Q46 = 46'd8380417;
    localparam logic [25:0] Q26 = 26'd8380417;

    logic [23:0] qhat;
    logic [25:0] r0;
    logic [25:0] r1;
    logic [25:0] r2;

    assign qhat = 24'(({24'b0, x_i} * M) >> 46);
    assign r0   = 26'(x_i - ({22'b0, qhat} * Q46));
    assign r1   = (r0 >= Q26) ? (r0 - Q26) : r0;
    assign r2   = (r1 >= Q26) ? (r1 - Q26) : r1;
    assign r_o  = r2[22:0];
endmodule

module pw_mul_ctrl #(
    parameter int N_COEF = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [22:0]       a_i,
    input  logic [22:0]       b_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [22:0]       wr_data_o
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_COEF - 1);

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                v1_q, v1_d;
    logic [ADDR_W-1:0]   addr1_q, addr1_d;
    logic                v2_q, v2_d;
    logic [ADDR_W-1:0]   addr2_q, addr2_d;
    logic [45:0]         prod_q, prod_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [22:0]         wr_data_q, wr_data_d;
    logic [22:0]         red_out;

    red_D u_red (
        .x_i (prod_q),
        .r_o (red_out)
    );

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_en_d   = rd_en_q;
        rd_addr_d = rd_addr_q;

        // Valid bits and addresses ride alongside the data; the pipe empties itself.
        v1_d      = rd_en_q;
        addr1_d   = rd_addr_q;
        prod_d    = v1_q ? ({23'b0, a_i} * {23'b0, b_i}) : prod_q;
        v2_d      = v1_q;
        addr2_d   = addr1_q;
        wr_en_d   = v2_q;
        wr_addr_d = v2_q ? addr2_q : wr_addr_q;
        wr_data_d = v2_q ? red_out : wr_data_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = RUN;
                    busy_d    = 1'b1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                end
            end
            RUN: begin
                if (rd_addr_q == LAST) begin
                    state_d = DRAIN;
                    rd_en_d = 1'b0;
                end else begin
                    rd_addr_d = rd_addr_q + 1'b1;
                end
            end
            DRAIN: begin
                if (wr_en_q && (wr_addr_q == LAST)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            v1_q      <= 1'b0;
            addr1_q   <= '0;
            v2_q      <= 1'b0;
            addr2_q   <= '0;
            prod_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            v1_q      <= v1_d;
            addr1_q   <= addr1_d;
            v2_q      <= v2_d;
            addr2_q   <= addr2_d;
            prod_q    <= prod_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign rd_en_o   = rd_en_q;
    assign rd_addr_o = rd_addr_q;
    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
endmodule

// File: tb/tb_pw_mul_ctrl.sv
// Self-checking bench for pw_mul_ctrl: directed and random operand sets,
// cycle-exact timing checks, start-hold/glitch behaviour and mid-run reset.

module tb_pw_mul_ctrl;
    localparam int N = 256;
    localparam int AW = 8;
    localparam longint unsigned QMOD = 64'd8380417;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          busy_o, done_o, rd_en_o, wr_en_o;
    logic [AW-1:0] rd_addr_o, wr_addr_o;
    logic [22:0]   a_i, b_i, wr_data_o;

    logic [22:0] mem_a [0:N-1];
    logic [22:0] mem_b [0:N-1];

    int checks = 0;
    int errors = 0;

    pw_mul_ctrl #(.N_COEF(N), .ADDR_W(AW)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .rd_en_o   (rd_en_o),
        .rd_addr_o (rd_addr_o),
        .a_i       (a_i),
        .b_i       (b_i),
        .wr_en_o   (wr_en_o),
        .wr_addr_o (wr_addr_o),
        .wr_data_o (wr_data_o)
    );

    always #5 clk_i = ~clk_i;

    // Operand RAMs with one cycle of read latency.
    always @(posedge clk_i) begin
        if (rd_en_o) begin
            a_i <= mem_a[rd_addr_o];
            b_i <= mem_b[rd_addr_o];
        end
    end

    function automatic logic [22:0] ref_mul(input logic [22:0] a, input logic [22:0] b);
        longint unsigned p;
        p = 64'(a) * 64'(b);
        return 23'(p % QMOD);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".busy"},    64'(busy_o),    64'd0);
        check({tag, ".done"},    64'(done_o),    64'd0);
        check({tag, ".rd_en"},   64'(rd_en_o),   64'd0);
        check({tag, ".rd_addr"}, 64'(rd_addr_o), 64'd0);
        check({tag, ".wr_en"},   64'(wr_en_o),   64'd0);
        check({tag, ".wr_addr"}, 64'(wr_addr_o), 64'd0);
        check({tag, ".wr_data"}, 64'(wr_data_o), 64'd0);
    endtask

    // mode: 0 a=1,b=k; 1 q-1,q-1; 2 q-1,2; 3 zeros; 4 all ones; 5 random
    task automatic fill(input int mode);
        for (int k = 0; k < N; k++) begin
            case (mode)
                0: begin mem_a[k] = 23'd1;       mem_b[k] = 23'(k); end
                1: begin mem_a[k] = 23'd8380416; mem_b[k] = 23'd8380416; end
                2: begin mem_a[k] = 23'd8380416; mem_b[k] = 23'd2; end
                3: begin mem_a[k] = 23'd0;       mem_b[k] = 23'd0; end
                4: begin mem_a[k] = 23'h7FFFFF;  mem_b[k] = 23'h7FFFFF; end
                default: begin
                    mem_a[k] = 23'($urandom);
                    mem_b[k] = 23'($urandom);
                end
            endcase
        end
    endtask

    // Called at a negedge; the following posedge is the start edge, c1 follows it.
    task automatic run_op(input string tag, input bit hold, input bit glitch, input int abort_at);
        int writes;
        writes = 0;
        start_i = 1'b1;
        for (int c = 1; c <= N + 5; c++) begin
            @(negedge clk_i);
            if (c == N + 5)      start_i = hold;
            else if (!hold)      start_i = glitch ? 1'($urandom_range(0, 1)) : 1'b0;
            if (c == abort_at) begin
                check({tag, ".abort_rd_addr"}, 64'(rd_addr_o), 64'd100);
                #2 rst_i = 1'b1;
                #1 check_zero({tag, ".async_rst"});
                start_i = 1'b0;
                @(negedge clk_i);
                @(negedge clk_i);
                check_zero({tag, ".in_rst"});
                rst_i = 1'b0;
                return;
            end
            check({tag, ".busy"}, 64'(busy_o), 64'(c <= N + 4));
            check({tag, ".done"}, 64'(done_o), 64'(c == N + 4));
            check({tag, ".rd_en"}, 64'(rd_en_o), 64'(c <= N));
            check({tag, ".rd_addr"}, 64'(rd_addr_o), (c <= N) ? 64'(c - 1) : 64'(N - 1));
            check({tag, ".wr_en"}, 64'(wr_en_o), 64'(c >= 4 && c <= N + 3));
            if (c >= 4) begin
                int k;
                k = (c <= N + 3) ? c - 4 : N - 1;
                check({tag, ".wr_addr"}, 64'(wr_addr_o), 64'(k));
                check({tag, ".wr_data"}, 64'(wr_data_o), 64'(ref_mul(mem_a[k], mem_b[k])));
                if (wr_en_o) writes++;
            end
        end
        check({tag, ".n_writes"}, 64'(writes), 64'(N));
        $display("op %s: %0d writes, checks=%0d errors=%0d", tag, writes, checks, errors);
    endtask

    task automatic idle_check(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_i);
            check({tag, ".busy"},  64'(busy_o),  64'd0);
            check({tag, ".done"},  64'(done_o),  64'd0);
            check({tag, ".rd_en"}, 64'(rd_en_o), 64'd0);
            check({tag, ".wr_en"}, 64'(wr_en_o), 64'd0);
        end
    endtask

    initial begin
        rst_i   = 1'b1;
        start_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        fill(3);
        @(negedge clk_i);
        @(negedge clk_i);
        check_zero("reset");
        rst_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            check_zero("idle");
        end

        fill(0); run_op("ramp", 1'b0, 1'b0, 0);     idle_check("gap", 3);
        fill(1); run_op("qm1_qm1", 1'b0, 1'b0, 0);  idle_check("gap", 2);
        fill(2); run_op("qm1_2", 1'b0, 1'b0, 0);    idle_check("gap", 2);
        fill(3); run_op("zero", 1'b0, 1'b0, 0);     idle_check("gap", 2);
        fill(4); run_op("allones", 1'b0, 1'b0, 0);  idle_check("gap", 2);

        for (int r = 0; r < 12; r++) begin
            fill(5);
            run_op("random", 1'b0, r[0], 0);
            idle_check("gap", 1);
        end

        // start held high: back-to-back ops with a single idle cycle between them
        fill(5);
        run_op("hold1", 1'b1, 1'b0, 0);
        run_op("hold2", 1'b1, 1'b0, 0);
        run_op("hold3", 1'b0, 1'b0, 0);
        idle_check("after_hold", 5);

        fill(5);
        run_op("abort", 1'b0, 1'b0, 101);
        idle_check("post_abort", N + 10);
        fill(5);
        run_op("clean", 1'b0, 1'b0, 0);
        idle_check("end", 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pw_mul_ctrl.md
Name: pw_mul_ctrl

Overview:
Sequencer for Dilithium pointwise polynomial multiplication. It streams N_COEF coefficient pairs from two synchronous-read coefficient RAMs and multiplies each pair in a registered 23x23 multiplier. Each 46-bit product is reduced by one red_D instance (Barrett, q = 8380417) and the result is written back to a result RAM. It sits between the NTT-domain polynomial memories and the reduction datapath, and owns all addressing and pipeline timing.

Parameters:
N_COEF, 256, number of coefficients per polynomial
ADDR_W, 8, coefficient address width; must satisfy 2^ADDR_W >= N_COEF

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  asynchronous, active-high reset
start_i  in  1  start request; sampled only in IDLE
busy_o  out  1  high from the first issue cycle through the DONE cycle
done_o  out  1  one-cycle pulse when the last result has been written
rd_en_o  out  1  read strobe to both operand RAMs
rd_addr_o  out  ADDR_W  read address, shared by both operand RAMs
a_i  in  23  operand A; valid the cycle after rd_en_o (1-cycle RAM latency)
b_i  in  23  operand B; same timing as a_i
wr_en_o  out  1  write strobe to the result RAM
wr_addr_o  out  ADDR_W  write address
wr_data_o  out  23  reduced product (a*b) mod 8380417

Behaviour:
- Reset (async, any state): FSM to IDLE; counters and pipeline valids cleared. busy_o, done_o, rd_en_o, wr_en_o = 0; rd_addr_o, wr_addr_o, wr_data_o = 0. Pipeline contents are discarded, with no further writes and no done_o. After rst_i falls, the block waits in IDLE for a new start_i.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start_i = 1 at a clock edge.
  - RUN -> DRAIN after the edge that issues address N_COEF-1.
  - DRAIN -> DONE when the last write has been presented.
  - DONE -> IDLE unconditionally after one cycle.
- RUN: rd_en_o = 1 every cycle. rd_addr_o counts 0..N_COEF-1 with no gaps, driven from registers (no start_i-to-output combinational path).
- Pipeline stages (k = coefficient index; c1 = first cycle after the start edge):
  - stage 0: address k issued in cycle c(k+1).
  - stage 1: a_i, b_i valid in c(k+2); the 46-bit unsigned product a_i*b_i is registered at the end of c(k+2).
  - stage 2: red_D reduces the product combinationally; the result register captures it at the end of c(k+3).
  - write: wr_en_o = 1, wr_addr_o = k, wr_data_o = result during c(k+4).
  - Write latency from issue is 3 cycles. Address travels with a valid bit through each stage.
- Full-length timing for N_COEF = 256:
  - reads in c1..c256, writes in c4..c259.
  - done_o = 1 in c260 only (DONE state).
  - busy_o = 1 in c1..c260; back in IDLE at c261.
- wr_en_o is never high outside c4..c(N_COEF+3). Exactly N_COEF writes per operation, each address written once, in ascending order.
- Arithmetic: operands are treated as unsigned 23-bit. The product is the full 46 bits with no truncation. wr_data_o equals (a_i*b_i) mod 8380417 for any 23-bit inputs, including inputs >= q.
- start_i while busy_o = 1 (including the DONE cycle) is ignored, not queued. A start asserted in the cycle after DONE (IDLE) is accepted normally, so back-to-back operations have a 1-cycle gap.
- rd_addr_o and wr_addr_o hold their last value when their strobe is low. wr_data_o holds its last value when wr_en_o = 0.

Test Plan:
- Reset then idle with start_i = 0 for 20 cycles -> all outputs 0, no rd_en_o/wr_en_o pulses.
- a[k] = 1, b[k] = k, one start -> 256 writes, wr_data_o = k at wr_addr_o = k. First write 3 cycles after the first read. done_o single pulse at c260; busy_o high exactly c1..c260.
- a = b = 8380416 (q-1) at all k -> every wr_data_o = 1. a = 8380416, b = 2 -> 8380415. a = b = 0 -> 0. a = b = 2^23-1 -> (2^23-1)^2 mod 8380417.
- Random 23-bit a, b (e.g. 1000 operations) -> each write matches a*b mod 8380417 from a reference model; addresses strictly ascending 0..255, no duplicates or gaps.
- start_i held high continuously -> operations repeat with busy_o low for exactly 1 cycle between them; start_i pulses during RUN/DRAIN/DONE cause no extra operation.
- rst_i asserted asynchronously mid-cycle while rd_addr_o = 100 -> all outputs 0 immediately, no further writes, no done_o. A subsequent start performs a full clean 256-write operation.
